mw_store_stage: RTL

- Memory-write (MW) stage of the 8-stage pipeline. Consumes the MR/MW pipeline-register outputs and retires stores into a DEPTH-entry FIFO store buffer.
- The store buffer drains to data memory over a req/ack write port.
- The stage selects writeback data (ALU result or loaded data) and registers it toward the MW/WB register, with one-cycle latency.
- It raises a stall when a store arrives and the buffer is full.

---
 rtl/mw_store_stage_if.sv | 21 ++
 rtl/mw_store_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mw_store_stage_if.sv
// Data-memory write port between the MW stage store buffer (master) and memory (slave).
interface mw_store_stage_if;
  logic        dmem_wr_req;
  logic [31:0] dmem_wr_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_wr_ack;

  modport master (
    output dmem_wr_req,
    output dmem_wr_addr,
    output dmem_wr_data,
    input  dmem_wr_ack
  );

  modport slave (
    input  dmem_wr_req,
    input  dmem_wr_addr,
    input  dmem_wr_data,
    output dmem_wr_ack
  );
endinterface

// File: rtl/mw_store_stage.sv
// Memory-write pipeline stage: writeback select/register plus a FIFO store buffer draining over req/ack.
// Optional store-to-load forwarding from the buffer is enabled by defining MW_STORE_FWD_EN.
module mw_store_stage #(
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = $clog2(SB_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemToReg_in,
  input  logic                 RegWrite_in,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic [31:0]          alu_result_in,
  input  logic [31:0]          read_data_in,
  input  logic [31:0]          rt_data_in,
  input  logic [4:0]           write_reg_in,
  output logic                 stall_out,
  output logic                 RegWrite_out,
  output logic [4:0]           write_reg_out,
  output logic [31:0]          wb_data_out,
  mw_store_stage_if.master     dmem,
  output logic                 sb_empty,
  output logic [CNT_W-1:0]     sb_count
);

  localparam int              PTR_W    = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

  logic [31:0]      sb_addr_mem [SB_DEPTH];
  logic [31:0]      sb_data_mem [SB_DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic             sb_full;
  logic             enq;
  logic             pop;
  logic [31:0]      load_data;

  // A full buffer blocks the incoming store even if the head pops this cycle.
  assign sb_full   = (count_reg == FULL_CNT);
  assign stall_out = MemWrite_in && sb_full;
  assign enq       = MemWrite_in && !sb_full;

  assign sb_empty          = (count_reg == '0);
  assign sb_count          = count_reg;
  assign dmem.dmem_wr_req  = !sb_empty;
  assign pop               = dmem.dmem_wr_req && dmem.dmem_wr_ack;

  // Head is gated so the port reads zero while empty or held in reset.
  assign dmem.dmem_wr_addr = sb_empty ? 32'h0 : sb_addr_mem[head_reg];
  assign dmem.dmem_wr_data = sb_empty ? 32'h0 : sb_data_mem[head_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({enq, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr_mem[tail_reg] <= alu_result_in;
      sb_data_mem[tail_reg] <= rt_data_in;
    end
  end

`ifdef MW_STORE_FWD_EN
  logic [SB_DEPTH-1:0] entry_hit;
  logic [PTR_W-1:0]    fwd_idx;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_fwd
      logic [PTR_W-1:0] age;
      // Age is distance from the head; entries younger than count are live.
      assign age           = PTR_W'(gi) - head_reg;
      assign entry_hit[gi] = (CNT_W'(age) < count_reg) &&
                             (sb_addr_mem[gi][31:2] == alu_result_in[31:2]);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    load_data = read_data_in;
    fwd_idx   = head_reg;
    if (MemRead_in) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        fwd_idx = head_reg + PTR_W'(k);
        if (entry_hit[fwd_idx]) begin
          load_data = sb_data_mem[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_mem_read;
  assign unused_mem_read = MemRead_in;
  assign load_data       = read_data_in;
`endif

  // A stalled cycle forwards a bubble to MW/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite_out  <= 1'b0;
      write_reg_out <= '0;
      wb_data_out   <= '0;
    end else if (stall_out) begin
      RegWrite_out  <= 1'b0;
      write_reg_out <= '0;
      wb_data_out   <= '0;
    end else begin
      RegWrite_out  <= RegWrite_in;
      write_reg_out <= write_reg_in;
      wb_data_out   <= MemToReg_in ? load_data : alu_result_in;
    end
  end

endmodule
